// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, MSB first, samples each bit at its centre using a CLK_FREQ/BAUD divider
// Ports: clk, rst_n (async active-low), rxd (async serial in, idle high),
//        rx_data (last good byte), rx_valid / rx_frame_err (one-cycle pulses), rx_busy (frame in progress)
module uart_rx #(
  parameter int CLK_FREQ = 48000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);
  localparam int BAUD_DIVIDOR = CLK_FREQ / BAUD;
  localparam logic [15:0] FULL = 16'(BAUD_DIVIDOR - 1);
  localparam logic [15:0] HALF = 16'(BAUD_DIVIDOR / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state;
  logic [1:0]  sync;
  logic        rxd_s;
  logic [15:0] sample_cntr;
  logic [3:0]  bit_cntr;
  logic [7:0]  shift_reg;
  logic        stop_err;
  assign rxd_s = sync[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync         <= 2'b11;
      state        <= IDLE;
      sample_cntr  <= '0;
      bit_cntr     <= '0;
      shift_reg    <= '0;
      stop_err     <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      sync         <= {sync[0], rxd};
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      sample_cntr  <= sample_cntr + 16'd1;
      case (state)
        IDLE: begin
          sample_cntr <= '0;
          if (!rxd_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: if (sample_cntr == HALF) begin
          sample_cntr <= '0;
          bit_cntr    <= '0;
          state       <= rxd_s ? IDLE : DATA;
          rx_busy     <= !rxd_s;
        end
        DATA: if (sample_cntr == FULL) begin
          sample_cntr <= '0;
          shift_reg   <= {shift_reg[6:0], rxd_s};
          bit_cntr    <= bit_cntr + 4'd1;
          if (bit_cntr == 4'd7) state <= STOP;
        end
        STOP: begin
          // after a bad stop bit, hold here until the line returns to idle
          if (stop_err) begin
            if (rxd_s) begin
              state    <= IDLE;
              rx_busy  <= 1'b0;
              stop_err <= 1'b0;
            end
          end else if (sample_cntr == FULL) begin
            sample_cntr <= '0;
            if (rxd_s) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
              state    <= IDLE;
              rx_busy  <= 1'b0;
            end else begin
              rx_frame_err <= 1'b1;
              stop_err     <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
